uart_rx_word_fifo: RTL and testbench

- Sits directly downstream of the UART byte receiver; consumes its one-cycle byte strobe and 8-bit data.
- Packs 4 consecutive bytes into a 32-bit word and buffers the words in a first-word-fall-through FIFO.
- The core reads input words (program load, data input) from the FIFO head.
- Removes byte-rate timing from the core: it sees only words, empty/full and a count.

---
 rtl/uart_rx_word_fifo.sv | 120 ++++++++++++
 tb/tb_uart_rx_word_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word_fifo.sv
// Packs UART receiver bytes into 32-bit words and buffers them in a first-word-fall-through FIFO.
// Optional macro RX_PARTIAL_TIMEOUT_EN discards a stale partial word after TIMEOUT idle cycles.
module uart_rx_word_fifo #(
  parameter int DEPTH      = 16,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 104160
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  input  logic                     rd_en,
  output logic [31:0]              word_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               partial_cnt,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("uart_rx_word_fifo: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_ovf;
  logic [1:0]    r_partial;
  logic [31:0]   r_asm;

  logic          w_push;
  logic          w_pop;
  logic          w_accept;
  logic [31:0]   w_word;
  logic [CW-1:0] w_count_nxt;

  // Places byte b into lane k of a word according to the configured byte order.
  function automatic logic [31:0] f_lane(input logic [1:0] k, input logic [7:0] b);
    logic [4:0] sh;
    sh = BIG_ENDIAN ? (5'd24 - {k, 3'b000}) : {k, 3'b000};
    return {24'd0, b} << sh;
  endfunction

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign w_push      = byte_valid && (r_partial == 2'd3);
  assign w_pop       = rd_en && !r_empty;
  assign w_accept    = w_push && (!r_full || w_pop);
  assign w_word      = r_asm | f_lane(2'd3, byte_in);
  assign w_count_nxt = r_count + CW'(w_accept) - CW'(w_pop);

  assign word_out    = r_mem[r_rptr];
  assign empty       = r_empty;
  assign full        = r_full;
  assign count       = r_count;
  assign partial_cnt = r_partial;
  assign overflow    = r_ovf;

`ifdef RX_PARTIAL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;
  logic          w_expire;

  assign w_expire = (r_partial != 2'd0) && (r_tmo == TW'(TIMEOUT));

  always_ff @(posedge CLK) begin
    if (RST || byte_valid || r_partial == 2'd0 || w_expire) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST && w_accept) begin
      r_mem[r_wptr] <= w_word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_ovf     <= 1'b0;
      r_partial <= 2'd0;
      r_asm     <= 32'd0;
    end else begin
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (w_push && r_full && !w_pop) r_ovf <= 1'b1;
      if (byte_valid) begin
        if (r_partial == 2'd3) begin
          r_partial <= 2'd0;
          r_asm     <= 32'd0;
        end else begin
          r_partial <= r_partial + 2'd1;
          r_asm     <= r_asm | f_lane(r_partial, byte_in);
        end
      end
`ifdef RX_PARTIAL_TIMEOUT_EN
      else if (w_expire) begin
        r_partial <= 2'd0;
        r_asm     <= 32'd0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Directed plus randomized bench for uart_rx_word_fifo against a queue-based reference model.
module tb_uart_rx_word_fifo;
  localparam int DEPTH = 16;
  localparam bit BE    = 1'b1;
  localparam int TMO   = 100;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] word_out;
  logic        empty;
  logic        full;
  logic [4:0]  count;
  logic [1:0]  partial_cnt;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mq[$];
  logic [7:0]  mp[$];
  bit          movf = 1'b0;
  int          midle = 0;

  uart_rx_word_fifo #(.DEPTH(DEPTH), .BIG_ENDIAN(BE), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .byte_in(byte_in), .byte_valid(byte_valid), .rd_en(rd_en),
    .word_out(word_out), .empty(empty), .full(full), .count(count),
    .partial_cnt(partial_cnt), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("count", 32'(count), 32'(mq.size()));
    chk("partial_cnt", 32'(partial_cnt), 32'(mp.size()));
    chk("overflow", 32'(overflow), 32'(movf));
    if (mq.size() > 0) chk("word_out", word_out, mq[0]);
  endtask

  // One clock: drive at negedge, update the model at posedge, check 1 time unit later.
  task automatic cyc(input logic rst, input logic bv, input logic [7:0] b, input logic rd);
    bit          pop;
    bit          was_full;
    logic [31:0] w;
    @(negedge CLK);
    RST = rst; byte_valid = bv; byte_in = b; rd_en = rd;
    @(posedge CLK);
    if (rst) begin
      mq.delete(); mp.delete(); movf = 1'b0; midle = 0;
    end else begin
      pop      = rd && (mq.size() > 0);
      was_full = (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      if (bv) begin
        mp.push_back(b);
        midle = 0;
        if (mp.size() == 4) begin
          w = BE ? {mp[0], mp[1], mp[2], mp[3]} : {mp[3], mp[2], mp[1], mp[0]};
          mp.delete();
          if (!was_full || pop) mq.push_back(w);
          else movf = 1'b1;
        end
      end
`ifdef RX_PARTIAL_TIMEOUT_EN
      else if (mp.size() != 0) begin
        if (midle == TMO) begin mp.delete(); midle = 0; end
        else midle++;
      end
`endif
    end
    #1 check_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rd);
    cyc(1'b0, 1'b1, b, rd);
    cyc(1'b0, 1'b0, 8'd0, rd);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    bit last_bv;
    bit bv;
    // Reset state
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // Basic word assembly
    send_word(32'h12345678);
    chk("first_word", word_out, 32'h12345678);
    chk("first_count", 32'(count), 32'd1);

    // Fill to full, then overflow with a 17th word, then drain in order
    do_reset();
    for (int k = 0; k < DEPTH; k++) send_word(32'(k));
    send_word(32'hDEADBEEF);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      chk("drain_order", word_out, 32'(k));
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Push and pop in the same cycle while full
    do_reset();
    for (int k = 0; k < DEPTH; k++) send_word(32'h100 + 32'(k));
    send_byte(8'hC0, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hEE, 1'b0);
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    chk("fullpop_count", 32'(count), 32'd16);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < DEPTH - 1; k++) cyc(1'b0, 1'b0, 8'd0, 1'b1);
    chk("fullpop_last", word_out, 32'hC0FFEE01);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);

    // Push while empty with rd_en asserted: rd_en ignored
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    cyc(1'b0, 1'b1, 8'h44, 1'b1);
    chk("empty_pushpop_count", 32'(count), 32'd1);

    // Reset mid-word discards partial bytes
    do_reset();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    do_reset();
    send_word(32'hAABBCCDD);
    chk("rst_mid_word", word_out, 32'hAABBCCDD);
    chk("rst_mid_count", 32'(count), 32'd1);

    // Randomized traffic: fill-biased first half, drain-biased second half
    do_reset();
    last_bv = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      bv = !last_bv && ($urandom_range(0, 1) == 0);
      cyc(1'b0, bv, 8'($urandom), (i < 600) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0));
      last_bv = bv;
    end

    // Lone byte followed by a long idle gap
    do_reset();
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < TMO + 20; i++) cyc(1'b0, 1'b0, 8'd0, 1'b0);
    send_word(32'hAABBCCDD);
`ifdef RX_PARTIAL_TIMEOUT_EN
    chk("timeout_word", word_out, 32'hAABBCCDD);
    chk("timeout_partial", 32'(partial_cnt), 32'd0);
`else
    chk("notimeout_word", word_out, 32'h01AABBCC);
    chk("notimeout_partial", 32'(partial_cnt), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
